// File: rtl/rv_fanout_fork.sv
// Registered ready/valid fork: a DEPTH-entry FIFO whose head word is offered to every
// enabled branch at once and retires only after each enabled branch has taken it.
module rv_fanout_fork #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 7,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic [NUM_OUT-1:0] branch_mask,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [NUM_OUT-1:0] done;
  logic               head_valid;
  logic               head_vis;
  logic               all_ok;
  logic               push;
  logic               pop;

  // Explicit wrap compare so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign head_vis   = head_valid & ~reset;

  // in_ready looks only at the registered count, never at out_ready.
  assign in_ready  = ~reset & (count < FULL_CNT);
  assign out_valid = head_vis ? (branch_mask & ~done) : '0;
  assign out_data  = head_vis ? mem[rd_ptr] : '0;

  assign all_ok = &(~branch_mask | done | out_ready);
  assign push   = in_valid & in_ready & clk_en;
  assign pop    = head_valid & all_ok & clk_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done   <= '0;
    end else if (clk_en) begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        done   <= '0;
      end else begin
        done <= done | (out_valid & out_ready);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only words below count are ever presented.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_rv_fanout_fork.sv
// Bench for rv_fanout_fork: directed scenarios plus a random phase, all checked by a
// negedge scoreboard that tracks unretired words and which branches have taken the head.
module tb_rv_fanout_fork;

  localparam int WIDTH   = 16;
  localparam int NUM_OUT = 7;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_en;
  logic [NUM_OUT-1:0] branch_mask;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int retired = 0;

  // Reference state: words accepted upstream but not yet retired, oldest first,
  // and which branches have already taken the oldest word.
  logic [WIDTH-1:0]   wq[$];
  logic [NUM_OUT-1:0] taken;

  rv_fanout_fork #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .branch_mask(branch_mask),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge everything is settled
  // and describes the handshakes that the coming posedge will perform.
  always @(negedge clk) begin
    logic [NUM_OUT-1:0] exp_v;
    logic               all_taken;
    logic               can_take;
    if (reset) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      wq.delete();
      taken = '0;
    end else begin
      exp_v = '0;
      if (wq.size() > 0)
        for (int i = 0; i < NUM_OUT; i++)
          exp_v[i] = branch_mask[i] && !taken[i];
      can_take = (wq.size() < DEPTH);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("in_ready", 32'(in_ready), 32'(can_take));
      chk("out_data", 32'(out_data), (wq.size() > 0) ? 32'(wq[0]) : 32'd0);
      if (clk_en) begin
        if (wq.size() > 0) begin
          taken = taken | (exp_v & out_ready);
          all_taken = 1'b1;
          for (int i = 0; i < NUM_OUT; i++)
            if (branch_mask[i] && !taken[i])
              all_taken = 1'b0;
          if (all_taken) begin
            void'(wq.pop_front());
            taken = '0;
            retired++;
          end
        end
        if (in_valid && can_take)
          wq.push_back(in_data);
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int r0;
    int waited;
    reset       = 1'b1;
    clk_en      = 1'b1;
    branch_mask = 7'h7F;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = '0;
    taken       = '0;
    step(3);
    reset = 1'b0;
    step(1);

    // Full fanout, all ready, five back-to-back words.
    out_ready = 7'h7F;
    r0 = retired;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k);
      step(1);
    end
    in_valid = 1'b0;
    step(2);
    chk("burst_retired", 32'(retired - r0), 32'd5);

    // Branch 0 takes early, branch 2 holds the head for three cycles.
    branch_mask = 7'h05;
    out_ready   = 7'b0000001;
    in_valid = 1'b1; in_data = 16'h00C5;
    step(1);
    in_valid = 1'b0;
    step(3);
    out_ready = 7'h7F;
    step(2);

    // Fill while stalled, third word held off, then drain in order.
    branch_mask = 7'h7F;
    out_ready   = '0;
    in_valid = 1'b1; in_data = 16'hAAAA; step(1);
    in_data = 16'hBBBB; step(1);
    in_data = 16'hCCCC; step(2);
    out_ready = 7'h7F;
    step(2);
    in_valid = 1'b0;
    step(3);

    // Empty mask: the block acts as a sink.
    branch_mask = '0;
    r0 = retired;
    in_valid = 1'b1; in_data = 16'h1234; step(1);
    in_valid = 1'b0; step(3);
    chk("sink_retired", 32'(retired - r0), 32'd1);

    // Reset while a head is pending with branch 1 already done.
    branch_mask = 7'h03;
    out_ready   = 7'b0000010;
    in_valid = 1'b1; in_data = 16'h5555; step(1);
    in_valid = 1'b0; step(2);
    reset = 1'b1; step(1);
    reset = 1'b0;
    out_ready = 7'h7F;
    step(2);

    // clk_en low freezes everything, then order is preserved.
    branch_mask = 7'h7F;
    out_ready   = '0;
    in_valid = 1'b1; in_data = 16'h6666; step(1);
    clk_en = 1'b0; in_data = 16'h7777; out_ready = 7'h7F;
    step(4);
    clk_en = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(3);

    // Random traffic, including mask changes mid-head, clock-enable gaps and rare resets.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = 7'($urandom) | 7'($urandom);
      clk_en    = ($urandom_range(0, 7) != 0);
      reset     = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0)
        branch_mask = ($urandom_range(0, 5) == 0) ? 7'h00 : 7'($urandom);
      step(1);
    end

    // Drain with a bounded wait.
    reset = 1'b0; clk_en = 1'b1; in_valid = 1'b0; out_ready = 7'h7F;
    waited = 0;
    while (wq.size() != 0 && waited < 50) begin
      step(1);
      waited++;
    end
    step(1);
    chk("drain_empty", 32'(wq.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
